// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction arbiter: APB register map of the
// byte-wide I2C master, FSM state encoding, latched request payload and the
// NBY register encoding.
package i2c_pkg;

  localparam logic [7:0] ADDR_NBY = 8'h00;
  localparam logic [7:0] ADDR_ADR = 8'h04;
  localparam logic [7:0] ADDR_RDR = 8'h08;
  localparam logic [7:0] ADDR_TDR = 8'h0C;
  localparam logic [7:0] ADDR_CFG = 8'h10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_NBY,
    S_WR_ADR,
    S_WR_TDR,
    S_WR_CFG,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RD_RDR,
    S_DONE
  } state_t;

  // Request fields captured at grant time
  typedef struct packed {
    logic        wr;
    logic [6:0]  addr;
    logic [2:0]  nb;
    logic [31:0] wdata;
  } txn_t;

  // Byte counts outside 1..4 are treated as a full word
  function automatic logic [2:0] nb_clamp(input logic [2:0] n);
    return (n == 3'd0 || n > 3'd4) ? 3'd4 : n;
  endfunction

  // NBY value the master expects for a given byte count
  function automatic logic [7:0] nby_enc(input logic [2:0] n);
    if (n == 3'd4) return 8'h04;
    return {5'b0, 1'b0, n[1], (~n[1] | n[0])};
  endfunction

  // States that drive an APB access
  function automatic logic is_apb(input state_t s);
    return (s == S_WR_NBY) || (s == S_WR_ADR) || (s == S_WR_TDR) ||
           (s == S_WR_CFG) || (s == S_RD_RDR);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. The scan starts one past the last completed grant.
//  clk, rst  : clock, async active-high reset
//  req       : request vector
//  take      : current pick is accepted (remembered as the active grant)
//  advance   : active grant finished, rotate priority past it
//  gnt_c     : combinational one-hot pick
//  any_c     : at least one request present
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             take,
  input  logic             advance,
  output logic [N_REQ-1:0] gnt_c,
  output logic             any_c
);

  localparam int unsigned IW = $clog2(N_REQ);

  logic [IW-1:0] last;
  logic [IW-1:0] cur;
  logic [IW-1:0] pick;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int unsigned off);
    return IW'((32'(base) + off) % N_REQ);
  endfunction

  // First asserted request after the last grant wins
  always_comb begin
    gnt_c = '0;
    any_c = 1'b0;
    pick  = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      if (!any_c && req[wrap_idx(last, i)]) begin
        any_c                    = 1'b1;
        gnt_c[wrap_idx(last, i)] = 1'b1;
        pick                     = wrap_idx(last, i);
      end
    end
  end

  // Reset value of last makes client 0 the first in line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= IW'(N_REQ - 1);
      cur  <= '0;
    end else begin
      if (take)    cur  <= pick;
      if (advance) last <= cur;
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one byte-wide APB I2C master among N_REQ clients. A granted request is
// turned into APB register writes (NBY, ADR, TDR bytes, CFG), the bus transfer
// is tracked through i2c_ready_i, RDR is read back for reads, and the result is
// returned with a one-cycle done_o pulse.
//  clk_i, rst_i              : clock, async active-high reset
//  req_i/write_i/dev_addr_i/
//  nbytes_i/wdata_i          : per-client request fields
//  done_o/err_o/rdata_o      : completion pulse, timeout flag, read payload
//  gnt_o                     : one-hot active grant
//  psel_o..pwdata_o,prdata_i : APB master port
//  i2c_ready_i               : I2C master idle
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter logic [3:0]  CFG_VAL     = 4'h1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_REQ-1:0]    req_i,
  input  logic [N_REQ-1:0]    write_i,
  input  logic [7*N_REQ-1:0]  dev_addr_i,
  input  logic [3*N_REQ-1:0]  nbytes_i,
  input  logic [32*N_REQ-1:0] wdata_i,
  output logic [N_REQ-1:0]    done_o,
  output logic                err_o,
  output logic [31:0]         rdata_o,
  output logic [N_REQ-1:0]    gnt_o,
  output logic                psel_o,
  output logic                penable_o,
  output logic                pwrite_o,
  output logic [7:0]          paddr_o,
  output logic [7:0]          pwdata_o,
  input  logic [7:0]          prdata_i,
  input  logic                i2c_ready_i
);

  localparam int unsigned TW = ($clog2(TIMEOUT_CYC) + 1 > 12) ? $clog2(TIMEOUT_CYC) + 1 : 12;

  state_t         state, state_n;
  logic           phase, phase_n;
  logic [1:0]     bcnt, bcnt_n;
  logic [TW-1:0]  tcnt, tcnt_n;
  txn_t           txn, txn_n, pick_txn;
  logic [31:0]    rbuf, rbuf_n;
  logic           to_err;
  logic           psel_n, penable_n, pwrite_n;
  logic [7:0]     paddr_n, pwdata_n;
  logic [N_REQ-1:0] gnt_c;
  logic           any_c;
  logic           take_c;
  logic           tmo_c;
  logic [1:0]     last_b_c;

  assign take_c   = (state == S_IDLE) && any_c;
  assign tmo_c    = (tcnt == TW'(TIMEOUT_CYC - 1));
  assign last_b_c = 2'(txn.nb - 3'd1);
  assign txn_n    = take_c ? pick_txn : txn;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk     (clk_i),
    .rst     (rst_i),
    .req     (req_i),
    .take    (take_c),
    .advance (state == S_DONE),
    .gnt_c   (gnt_c),
    .any_c   (any_c)
  );

  // Fields of the client picked by the arbiter
  always_comb begin
    pick_txn = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (gnt_c[k]) begin
        pick_txn.wr    = write_i[k];
        pick_txn.addr  = dev_addr_i[7*k +: 7];
        pick_txn.nb    = nb_clamp(nbytes_i[3*k +: 3]);
        pick_txn.wdata = wdata_i[32*k +: 32];
      end
    end
  end

  // Next state, sequencing counters and read capture
  always_comb begin
    state_n = state;
    to_err  = 1'b0;
    rbuf_n  = take_c ? '0 : rbuf;
    case (state)
      S_IDLE:      if (any_c) state_n = S_WR_NBY;
      S_WR_NBY:    if (phase) state_n = S_WR_ADR;
      S_WR_ADR:    if (phase) state_n = txn.wr ? S_WR_TDR : S_WR_CFG;
      S_WR_TDR:    if (phase && bcnt == last_b_c) state_n = S_WR_CFG;
      S_WR_CFG:    if (phase) state_n = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!i2c_ready_i) state_n = S_WAIT_DONE;
        else if (tmo_c) begin
          state_n = S_DONE;
          to_err  = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (i2c_ready_i) state_n = txn.wr ? S_DONE : S_RD_RDR;
        else if (tmo_c) begin
          state_n = S_DONE;
          to_err  = 1'b1;
        end
      end
      S_RD_RDR: begin
        if (phase) begin
          rbuf_n[{bcnt, 3'b000} +: 8] = prdata_i;
          if (bcnt == last_b_c) state_n = S_DONE;
        end
      end
      S_DONE:      state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase

    // Counters restart on every state entry; APB states alternate SETUP/ACCESS
    if (state_n != state) begin
      phase_n = 1'b0;
      bcnt_n  = 2'd0;
      tcnt_n  = '0;
    end else begin
      tcnt_n  = tcnt + 1'b1;
      phase_n = is_apb(state) ? ~phase : 1'b0;
      bcnt_n  = (is_apb(state) && phase) ? bcnt + 2'd1 : bcnt;
    end
  end

  // APB values for the cycle being entered, so the port is registered yet aligned
  always_comb begin
    psel_n   = is_apb(state_n);
    pwrite_n = 1'b0;
    paddr_n  = '0;
    pwdata_n = '0;
    case (state_n)
      S_WR_NBY: begin
        pwrite_n = 1'b1;
        paddr_n  = ADDR_NBY;
        pwdata_n = nby_enc(txn_n.nb);
      end
      S_WR_ADR: begin
        pwrite_n = 1'b1;
        paddr_n  = ADDR_ADR;
        pwdata_n = {1'b0, txn_n.addr};
      end
      S_WR_TDR: begin
        pwrite_n = 1'b1;
        paddr_n  = ADDR_TDR + {6'b0, bcnt_n};
        pwdata_n = txn_n.wdata[{bcnt_n, 3'b000} +: 8];
      end
      S_WR_CFG: begin
        pwrite_n = 1'b1;
        paddr_n  = ADDR_CFG;
        pwdata_n = {4'h0, CFG_VAL};
      end
      S_RD_RDR: paddr_n = ADDR_RDR + {6'b0, bcnt_n};
      default: ;
    endcase
    penable_n = psel_n & phase_n;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      phase     <= 1'b0;
      bcnt      <= '0;
      tcnt      <= '0;
      txn       <= '0;
      rbuf      <= '0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      gnt_o     <= '0;
      done_o    <= '0;
      err_o     <= 1'b0;
      rdata_o   <= '0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      bcnt      <= bcnt_n;
      tcnt      <= tcnt_n;
      txn       <= txn_n;
      rbuf      <= rbuf_n;
      psel_o    <= psel_n;
      penable_o <= penable_n;
      pwrite_o  <= pwrite_n;
      paddr_o   <= paddr_n;
      pwdata_o  <= pwdata_n;
      if (take_c)                 gnt_o <= gnt_c;
      else if (state_n == S_DONE) gnt_o <= '0;
      done_o <= (state_n == S_DONE) ? gnt_o : '0;
      if (state_n == S_DONE) begin
        err_o   <= to_err;
        rdata_o <= to_err ? 32'h0 : rbuf_n;
      end
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter: expected APB accesses and completions
// are queued by the stimulus and consumed by an independent monitor.
module tb_i2c_txn_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [3:0]   req_i;
  logic [3:0]   write_i;
  logic [27:0]  dev_addr_i;
  logic [11:0]  nbytes_i;
  logic [127:0] wdata_i;
  logic [3:0]   done_o;
  logic         err_o;
  logic [31:0]  rdata_o;
  logic [3:0]   gnt_o;
  logic         psel_o, penable_o, pwrite_o;
  logic [7:0]   paddr_o, pwdata_o;
  logic [7:0]   prdata_i;
  logic         i2c_ready_i;

  typedef struct {
    bit          is_done;
    bit          wr;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [3:0]  gnt;
    bit          err;
    bit          chk_rd;
    logic [31:0] rdata;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          cfg_cyc = 0;
  int          mon_done_cyc = 0;
  bit          after_done = 0;
  bit          prev_psel = 0;
  bit          chk_gap = 0;
  bit          stuck = 0;
  logic [31:0] rdr = 32'h0;

  i2c_txn_arbiter #(.N_REQ(4), .TIMEOUT_CYC(64), .CFG_VAL(4'h1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .write_i(write_i),
    .dev_addr_i(dev_addr_i), .nbytes_i(nbytes_i), .wdata_i(wdata_i),
    .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .gnt_o(gnt_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .prdata_i(prdata_i),
    .i2c_ready_i(i2c_ready_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // RDR slave model
  always_comb begin
    prdata_i = 8'h00;
    if (paddr_o >= 8'h08 && paddr_o <= 8'h0B) prdata_i = rdr[{paddr_o[1:0], 3'b000} +: 8];
  end

  // I2C master busy model: busy 3 cycles after CFG, idle again 20 cycles later
  always begin
    @(negedge clk_i);
    if (!rst_i && !stuck && psel_o && penable_o && pwrite_o && paddr_o == 8'h10) begin
      repeat (3) @(negedge clk_i);
      i2c_ready_i = 1'b0;
      repeat (20) @(negedge clk_i);
      i2c_ready_i = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic push_apb(input bit wr, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e = '{default: '0};
    e.wr = wr; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int c, input bit err, input bit chk_rd, input logic [31:0] rd);
    ev_t e;
    e = '{default: '0};
    e.is_done = 1'b1; e.gnt = 4'(1 << c); e.err = err; e.chk_rd = chk_rd; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  // Expected access sequence of a successful transaction
  task automatic push_txn(input int c, input bit wr, input logic [6:0] a, input int nraw,
                          input logic [31:0] wd, input logic [31:0] rd);
    int n;
    logic [31:0] m;
    n = (nraw == 0 || nraw > 4) ? 4 : nraw;
    m = 32'h0;
    push_apb(1'b1, 8'h00, 8'(n));
    push_apb(1'b1, 8'h04, {1'b0, a});
    if (wr) for (int b = 0; b < n; b++) push_apb(1'b1, 8'(8'h0C + b), wd[8*b +: 8]);
    push_apb(1'b1, 8'h10, 8'h01);
    if (!wr) for (int b = 0; b < n; b++) begin
      push_apb(1'b0, 8'(8'h08 + b), 8'h00);
      m[8*b +: 8] = rd[8*b +: 8];
    end
    push_done(c, 1'b0, !wr, m);
  endtask

  task automatic set_client(input int c, input bit wr, input logic [6:0] a,
                            input logic [2:0] n, input logic [31:0] wd);
    write_i[c]         = wr;
    dev_addr_i[7*c +: 7] = a;
    nbytes_i[3*c +: 3]   = n;
    wdata_i[32*c +: 32]  = wd;
  endtask

  task automatic wait_done(input int budget, output int at);
    bit ok;
    ok = 0;
    at = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (done_o != 4'h0) begin ok = 1; at = cyc; break; end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout no done_o within %0d cycles", budget);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an access or a completion
  always @(negedge clk_i) begin
    ev_t e;
    if (rst_i) begin
      prev_psel  = 0;
      after_done = 0;
    end else begin
      if (psel_o && !prev_psel && after_done) begin
        if (chk_gap) chk("idle_gap", 64'(cyc - mon_done_cyc), 64'd2);
        after_done = 0;
      end
      prev_psel = psel_o;
      if (psel_o && penable_o) begin
        if (pwrite_o && paddr_o == 8'h10) cfg_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("apb_unexpected", {pwrite_o, paddr_o}, 64'h0);
          checks--;
          if ({pwrite_o, paddr_o} == 9'h0) begin errors++; $display("FAIL apb_unexpected got 0 exp none"); end
          checks++;
        end else begin
          e = exp_q.pop_front();
          chk("apb_access", {e.is_done, pwrite_o, paddr_o, pwrite_o ? pwdata_o : 8'h00},
                            {1'b0, e.wr, e.addr, e.wr ? e.data : 8'h00});
        end
      end
      if (done_o != 4'h0) begin
        after_done   = 1;
        mon_done_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected got %0h exp none", done_o);
        end else begin
          e = exp_q.pop_front();
          chk("done_evt", {e.is_done, done_o, err_o, e.chk_rd ? rdata_o : 32'h0},
                          {1'b1, e.gnt, e.err, e.chk_rd ? e.rdata : 32'h0});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    bit hit;
    rst_i = 1'b1; req_i = '0; write_i = '0; dev_addr_i = '0; nbytes_i = '0; wdata_i = '0;
    i2c_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_psel", psel_o, 0);
    chk("rst_penable", penable_o, 0);
    chk("rst_apb_bus", {pwrite_o, paddr_o, pwdata_o}, 0);
    chk("rst_gnt_done", {gnt_o, done_o}, 0);
    chk("rst_err_rdata", {err_o, rdata_o}, 0);
    rst_i = 1'b0;

    // All four requesting: strict rotation starting at client 0
    set_client(0, 1'b1, 7'h10, 3'd1, 32'h000000A1);
    set_client(1, 1'b0, 7'h21, 3'd1, 32'h0);
    set_client(2, 1'b1, 7'h32, 3'd1, 32'h000000C3);
    set_client(3, 1'b0, 7'h43, 3'd2, 32'h0);
    rdr = 32'h11223344;
    for (int r = 0; r < 2; r++) begin
      push_txn(0, 1'b1, 7'h10, 1, 32'h000000A1, rdr);
      push_txn(1, 1'b0, 7'h21, 1, 32'h0, rdr);
      push_txn(2, 1'b1, 7'h32, 1, 32'h000000C3, rdr);
      push_txn(3, 1'b0, 7'h43, 2, 32'h0, rdr);
    end
    chk_gap = 1;
    req_i = 4'hF;
    for (int i = 0; i < 8; i++) wait_done(300, t);
    req_i = 4'h0;
    chk_gap = 0;

    // Client 0 write, two bytes
    set_client(0, 1'b1, 7'h50, 3'd2, 32'h0000BEEF);
    push_apb(1'b1, 8'h00, 8'h02);
    push_apb(1'b1, 8'h04, 8'h50);
    push_apb(1'b1, 8'h0C, 8'hEF);
    push_apb(1'b1, 8'h0D, 8'hBE);
    push_apb(1'b1, 8'h10, 8'h01);
    push_done(0, 1'b0, 1'b0, 32'h0);
    req_i = 4'b0001;
    wait_done(200, t);
    req_i = 4'h0;
    repeat (3) @(negedge clk_i);
    chk("single_done_pulse", done_o, 0);

    // Client 2 read, four bytes
    set_client(2, 1'b0, 7'h2A, 3'd4, 32'h0);
    rdr = 32'hCAFEF00D;
    push_apb(1'b1, 8'h00, 8'h04);
    push_apb(1'b1, 8'h04, 8'h2A);
    push_apb(1'b1, 8'h10, 8'h01);
    push_apb(1'b0, 8'h08, 8'h00);
    push_apb(1'b0, 8'h09, 8'h00);
    push_apb(1'b0, 8'h0A, 8'h00);
    push_apb(1'b0, 8'h0B, 8'h00);
    push_done(2, 1'b0, 1'b1, 32'hCAFEF00D);
    req_i = 4'b0100;
    wait_done(200, t);
    req_i = 4'h0;
    repeat (4) @(negedge clk_i);
    chk("rdata_hold", {err_o, rdata_o}, {1'b0, 32'hCAFEF00D});

    // Ready stuck high: timeout after 64 cycles in WAIT_BUSY
    stuck = 1;
    set_client(1, 1'b0, 7'h3C, 3'd1, 32'h0);
    push_apb(1'b1, 8'h00, 8'h01);
    push_apb(1'b1, 8'h04, 8'h3C);
    push_apb(1'b1, 8'h10, 8'h01);
    push_done(1, 1'b1, 1'b1, 32'h0);
    req_i = 4'b0010;
    wait_done(200, t);
    req_i = 4'h0;
    chk("timeout_latency", 64'(t - cfg_cyc), 64'd65);
    repeat (3) @(negedge clk_i);
    chk("err_hold", {err_o, rdata_o}, {1'b1, 32'h0});
    stuck = 0;

    // Out-of-range byte counts behave as four bytes
    set_client(0, 1'b1, 7'h55, 3'd0, 32'h44332211);
    push_txn(0, 1'b1, 7'h55, 0, 32'h44332211, 32'h0);
    req_i = 4'b0001;
    wait_done(200, t);
    req_i = 4'h0;
    set_client(2, 1'b0, 7'h66, 3'd7, 32'h0);
    rdr = 32'h8899AABB;
    push_txn(2, 1'b0, 7'h66, 7, 32'h0, rdr);
    req_i = 4'b0100;
    wait_done(200, t);
    req_i = 4'h0;

    // Reset during TDR writes, then client 0 wins over client 3
    set_client(1, 1'b1, 7'h77, 3'd4, 32'hDDCCBBAA);
    push_apb(1'b1, 8'h00, 8'h04);
    push_apb(1'b1, 8'h04, 8'h77);
    req_i = 4'b0010;
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (psel_o && !penable_o && paddr_o == 8'h0C) begin hit = 1; break; end
    end
    chk("reach_wr_tdr", hit, 1);
    rst_i = 1'b1;
    #1;
    chk("rst_mid_psel_penable", {psel_o, penable_o}, 0);
    chk("rst_mid_gnt_done", {gnt_o, done_o}, 0);
    chk("sb_before_rst", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    set_client(0, 1'b1, 7'h12, 3'd1, 32'h00000099);
    set_client(3, 1'b1, 7'h13, 3'd1, 32'h00000098);
    push_txn(0, 1'b1, 7'h12, 1, 32'h00000099, 32'h0);
    req_i = 4'b1001;
    rst_i = 1'b0;
    wait_done(200, t);
    req_i = 4'h0;

    repeat (5) @(negedge clk_i);
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
